// File: rtl/sync_fifo_reader_if.sv
// rtl/sync_fifo_reader_if.sv - FIFO read port plus valid/ready output stream of sync_fifo_reader
interface sync_fifo_reader_if #(
   parameter int FIFO_WIDTH = 16
);
   logic                  fifo_rd;
   logic [FIFO_WIDTH-1:0] fifo_do;
   logic                  fifo_empty;
   logic                  m_valid;
   logic                  m_ready;
   logic [FIFO_WIDTH-1:0] m_data;

   modport master (
      output fifo_rd,
      input  fifo_do,
      input  fifo_empty,
      output m_valid,
      input  m_ready,
      output m_data
   );

   modport slave (
      input  fifo_rd,
      output fifo_do,
      output fifo_empty,
      input  m_valid,
      output m_ready,
      input  m_data
   );
endinterface

// File: rtl/sync_fifo_reader.sv
// rtl/sync_fifo_reader.sv - pops a show-ahead FIFO into a 2-entry skid buffer feeding a valid/ready stream
module sync_fifo_reader #(
   parameter int FIFO_WIDTH = 16,
   parameter int CNT_W      = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   en,
   input  logic                   flush,
   sync_fifo_reader_if.master     bus,
   output logic                   busy,
   output logic [CNT_W-1:0]       xfer_cnt,
   output logic [CNT_W-1:0]       drop_cnt
);

   typedef enum logic {ST_STREAM, ST_FLUSH} state_t;

   state_t                state, state_nxt;
   logic [1:0]            occ, occ_nxt;
   logic [FIFO_WIDTH-1:0] e0, e1, e0_nxt, e1_nxt;
   logic                  run;
   logic                  pop, deq;
   logic [1:0]            drop_inc;

   always_comb begin
      state_nxt = state;
      occ_nxt   = occ;
      e0_nxt    = e0;
      e1_nxt    = e1;
      drop_inc  = 2'd0;
      // pop never depends on m_ready, so no combinational ready-to-read path exists
      if (state == ST_FLUSH) begin
         pop = run & ~bus.fifo_empty;
      end else begin
         pop = run & en & ~bus.fifo_empty & (occ != 2'd2);
      end
      deq = (occ != 2'd0) & bus.m_ready;

      if (flush) begin
         state_nxt = ST_FLUSH;
         occ_nxt   = 2'd0;
         drop_inc  = occ + {1'b0, pop} - {1'b0, deq};
      end else if (state == ST_FLUSH) begin
         drop_inc = {1'b0, pop};
         if (bus.fifo_empty) begin
            state_nxt = ST_STREAM;
         end
      end else begin
         case ({pop, deq})
            2'b10: begin
               if (occ == 2'd0) begin
                  e0_nxt = bus.fifo_do;
               end else begin
                  e1_nxt = bus.fifo_do;
               end
               occ_nxt = occ + 2'd1;
            end
            2'b01: begin
               e0_nxt  = e1;
               occ_nxt = occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd2) begin
                  e0_nxt = e1;
                  e1_nxt = bus.fifo_do;
               end else begin
                  e0_nxt = bus.fifo_do;
               end
            end
            default: ;
         endcase
      end
   end

   // run holds off popping until the first clock edge after reset release
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= ST_STREAM;
         occ      <= 2'd0;
         e0       <= '0;
         e1       <= '0;
         run      <= 1'b0;
         xfer_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         state    <= state_nxt;
         occ      <= occ_nxt;
         e0       <= e0_nxt;
         e1       <= e1_nxt;
         run      <= 1'b1;
         xfer_cnt <= xfer_cnt + CNT_W'(deq);
         drop_cnt <= drop_cnt + CNT_W'(drop_inc);
      end
   end

   assign bus.fifo_rd = pop;
   assign bus.m_valid = (occ != 2'd0);
   assign bus.m_data  = e0;
   assign busy        = (state == ST_FLUSH);

endmodule

// File: tb/tb_sync_fifo_reader.sv
// tb/tb_sync_fifo_reader.sv - bench for sync_fifo_reader against a queue-based FIFO and scoreboard
module tb_sync_fifo_reader;
   localparam int W  = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rstn, en, flush, busy;
   logic [CW-1:0] xfer_cnt, drop_cnt;

   sync_fifo_reader_if #(.FIFO_WIDTH(W)) bif();

   sync_fifo_reader #(.FIFO_WIDTH(W), .CNT_W(CW)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .en       (en),
      .flush    (flush),
      .bus      (bif.master),
      .busy     (busy),
      .xfer_cnt (xfer_cnt),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   logic         push_req;
   logic [W-1:0] push_data;
   logic         rd_s, push_s;
   logic [W-1:0] pdata_s;
   logic [W-1:0] fifo_q[$];
   logic [W-1:0] got_q[$];
   int           got_cyc[$];
   int cyc_n = 0, rd_total = 0, rd_empty_err = 0;
   int pass = 0, total = 0, exp_xfer = 0, exp_drop = 0;

   // observe handshakes mid-cycle; they take effect at the following posedge
   always @(negedge clk) begin
      cyc_n++;
      rd_s    = bif.fifo_rd;
      push_s  = push_req;
      pdata_s = push_data;
      if (bif.fifo_rd === 1'b1) begin
         rd_total++;
         if (bif.fifo_empty !== 1'b0) rd_empty_err++;
      end
      if (bif.m_valid === 1'b1 && bif.m_ready === 1'b1) begin
         got_q.push_back(bif.m_data);
         got_cyc.push_back(cyc_n);
      end
   end

   // show-ahead FIFO model
   always @(posedge clk) begin
      if (rd_s === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
      if (push_s === 1'b1) fifo_q.push_back(pdata_s);
      bif.fifo_empty <= (fifo_q.size() == 0);
      bif.fifo_do    <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_seq(input int n, input logic [W-1:0] base);
      for (int i = 0; i < n; i++) begin
         push_req  = 1'b1;
         push_data = base + W'(i);
         step(1);
      end
      push_req = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; en = 1'b0; flush = 1'b0;
      push_req = 1'b0; push_data = '0; bif.m_ready = 1'b0;
      step(3);
      total++; if (bif.m_valid !== 1'b0) $display("FAIL reset_m_valid got=%b exp=0", bif.m_valid); else pass++;
      total++; if (bif.fifo_rd !== 1'b0) $display("FAIL reset_fifo_rd got=%b exp=0", bif.fifo_rd); else pass++;
      total++; if (bif.m_data !== '0) $display("FAIL reset_m_data got=%h exp=0", bif.m_data); else pass++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass++;
      total++; if (xfer_cnt !== '0) $display("FAIL reset_xfer got=%0d exp=0", xfer_cnt); else pass++;
      total++; if (drop_cnt !== '0) $display("FAIL reset_drop got=%0d exp=0", drop_cnt); else pass++;
      rstn = 1'b1;
      step(2);
      exp_xfer = 0; exp_drop = 0;
   endtask

   task automatic test_stream();
      int r0, bad;
      got_q.delete(); got_cyc.delete();
      bif.m_ready = 1'b1; en = 1'b0;
      push_seq(6, 16'h0001);
      step(1);
      r0 = rd_total;
      en = 1'b1;
      step(10);
      total++; if (rd_total - r0 != 6) $display("FAIL stream_pops got=%0d exp=6", rd_total - r0); else pass++;
      total++; if (got_q.size() != 6) $display("FAIL stream_count got=%0d exp=6", got_q.size()); else pass++;
      bad = 0;
      for (int i = 0; i < got_q.size(); i++) begin
         if (got_q[i] !== W'(i + 1)) bad++;
         if (got_cyc[i] != got_cyc[0] + i) bad++;
      end
      total++; if (bad != 0) $display("FAIL stream_order_b2b got=%0d errors exp=0", bad); else pass++;
      exp_xfer += 6;
      total++; if (xfer_cnt !== CW'(exp_xfer)) $display("FAIL stream_xfer got=%0d exp=%0d", xfer_cnt, CW'(exp_xfer)); else pass++;
      total++; if (bif.fifo_rd !== 1'b0) $display("FAIL stream_idle_rd got=%b exp=0", bif.fifo_rd); else pass++;
   endtask

   task automatic test_backpressure();
      int r0, bad;
      got_q.delete();
      bif.m_ready = 1'b0; en = 1'b1;
      r0 = rd_total;
      push_seq(6, 16'h0011);
      step(6);
      total++; if (rd_total - r0 != 2) $display("FAIL bp_pops got=%0d exp=2", rd_total - r0); else pass++;
      total++; if (bif.m_valid !== 1'b1) $display("FAIL bp_valid got=%b exp=1", bif.m_valid); else pass++;
      total++; if (bif.m_data !== 16'h0011) $display("FAIL bp_hold got=%h exp=0011", bif.m_data); else pass++;
      total++; if (fifo_q.size() != 4) $display("FAIL bp_fifo_left got=%0d exp=4", fifo_q.size()); else pass++;
      bif.m_ready = 1'b1;
      step(12);
      bad = (got_q.size() == 6) ? 0 : 1;
      for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 16'h0011 + W'(i)) bad++;
      total++; if (bad != 0) $display("FAIL bp_sequence got=%0d words/%0d errors exp=6/0", got_q.size(), bad); else pass++;
      exp_xfer += 6;
      total++; if (xfer_cnt !== CW'(exp_xfer)) $display("FAIL bp_xfer got=%0d exp=%0d", xfer_cnt, CW'(exp_xfer)); else pass++;
   endtask

   task automatic test_random();
      logic [W-1:0] exp_q[$];
      int bad;
      got_q.delete();
      en = 1'b1;
      for (int c = 0; c < 200; c++) begin
         push_req  = ($urandom_range(0, 1) == 1) && (fifo_q.size() < 16);
         push_data = W'($urandom);
         if (push_req) exp_q.push_back(push_data);
         bif.m_ready = ($urandom_range(0, 1) == 1);
         step(1);
      end
      push_req = 1'b0;
      bif.m_ready = 1'b1;
      step(40);
      total++; if (got_q.size() != exp_q.size()) $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else pass++;
      bad = 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
      total++; if (bad != 0) $display("FAIL rand_order got=%0d errors exp=0", bad); else pass++;
      total++; if (rd_empty_err != 0) $display("FAIL rand_rd_when_empty got=%0d exp=0", rd_empty_err); else pass++;
      exp_xfer += exp_q.size();
      total++; if (xfer_cnt !== CW'(exp_xfer)) $display("FAIL rand_xfer got=%0d exp=%0d", xfer_cnt, CW'(exp_xfer)); else pass++;
   endtask

   task automatic test_flush();
      int waited;
      got_q.delete();
      bif.m_ready = 1'b0; en = 1'b1;
      push_seq(6, 16'h0021);
      step(6);
      total++; if (bif.m_valid !== 1'b1) $display("FAIL flush_pre_valid got=%b exp=1", bif.m_valid); else pass++;
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      total++; if (bif.m_valid !== 1'b0) $display("FAIL flush_valid got=%b exp=0", bif.m_valid); else pass++;
      total++; if (busy !== 1'b1) $display("FAIL flush_busy got=%b exp=1", busy); else pass++;
      waited = 0;
      while (busy === 1'b1 && waited < 20) begin
         step(1);
         waited++;
      end
      total++; if (busy !== 1'b0) $display("FAIL flush_done got=%b exp=0 (timeout)", busy); else pass++;
      exp_drop += 6;
      total++; if (drop_cnt !== CW'(exp_drop)) $display("FAIL flush_drop got=%0d exp=%0d", drop_cnt, CW'(exp_drop)); else pass++;
      total++; if (fifo_q.size() != 0 || got_q.size() != 0) $display("FAIL flush_drained got=%0d/%0d exp=0/0", fifo_q.size(), got_q.size()); else pass++;
      bif.m_ready = 1'b1;
      push_seq(1, 16'hBEEF);
      step(4);
      total++; if (got_q.size() != 1 || got_q[0] !== 16'hBEEF) $display("FAIL flush_resume got=%0d words exp=1 word BEEF", got_q.size()); else pass++;
      exp_xfer += 1;
      total++; if (xfer_cnt !== CW'(exp_xfer)) $display("FAIL flush_xfer got=%0d exp=%0d", xfer_cnt, CW'(exp_xfer)); else pass++;
   endtask

   task automatic test_enable();
      int r0, bad;
      got_q.delete();
      bif.m_ready = 1'b0; en = 1'b1;
      push_seq(6, 16'h0031);
      step(6);
      en = 1'b0;
      r0 = rd_total;
      bif.m_ready = 1'b1;
      step(6);
      total++; if (rd_total - r0 != 0) $display("FAIL en_no_pop got=%0d exp=0", rd_total - r0); else pass++;
      bad = (got_q.size() == 2) ? 0 : 1;
      for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 16'h0031 + W'(i)) bad++;
      total++; if (bad != 0) $display("FAIL en_drain got=%0d words/%0d errors exp=2/0", got_q.size(), bad); else pass++;
      en = 1'b1;
      step(10);
      bad = (got_q.size() == 6) ? 0 : 1;
      for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 16'h0031 + W'(i)) bad++;
      total++; if (bad != 0) $display("FAIL en_resume got=%0d words/%0d errors exp=6/0", got_q.size(), bad); else pass++;
      exp_xfer += 6;
      total++; if (xfer_cnt !== CW'(exp_xfer)) $display("FAIL en_xfer got=%0d exp=%0d", xfer_cnt, CW'(exp_xfer)); else pass++;
   endtask

   task automatic test_reset_wrap();
      int bad;
      got_q.delete();
      bif.m_ready = 1'b0; en = 1'b1;
      push_seq(2, 16'h0041);
      step(3);
      total++; if (bif.m_valid !== 1'b1) $display("FAIL rst_pre_valid got=%b exp=1", bif.m_valid); else pass++;
      rstn = 1'b0;
      #1;
      total++; if (bif.m_valid !== 1'b0) $display("FAIL rst_async_valid got=%b exp=0", bif.m_valid); else pass++;
      total++; if (xfer_cnt !== '0 || drop_cnt !== '0) $display("FAIL rst_async_cnt got=%0d/%0d exp=0/0", xfer_cnt, drop_cnt); else pass++;
      total++; if (busy !== 1'b0) $display("FAIL rst_async_busy got=%b exp=0", busy); else pass++;
      step(2);
      rstn = 1'b1;
      step(1);
      got_q.delete();
      exp_xfer = 0;
      bif.m_ready = 1'b1;
      push_seq(17, 16'h0100);
      step(6);
      bad = (got_q.size() == 17) ? 0 : 1;
      for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 16'h0100 + W'(i)) bad++;
      total++; if (bad != 0) $display("FAIL wrap_sequence got=%0d words/%0d errors exp=17/0", got_q.size(), bad); else pass++;
      exp_xfer += 17;
      total++; if (xfer_cnt !== CW'(exp_xfer)) $display("FAIL wrap_xfer got=%0d exp=%0d", xfer_cnt, CW'(exp_xfer)); else pass++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_random();
      test_flush();
      test_enable();
      test_reset_wrap();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
